// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle MIPS32 datapath.
// Stores commit on the rising clock edge; loads are combinational.
module data_memory #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_invalue,
  input  logic        i_memwrite,
  input  logic        i_memread,
  output logic [31:0] o_outvalue
);

  logic [31:0]   r_mem [WORDS];
  logic [AW-1:0] w_idx;
  logic          w_we;
  logic          w_re;

  // Byte offset and high address bits are don't-care: whole-word, wrapping.
  logic [31-AW:0] w_unused_addr;

  assign w_idx         = i_addr[AW+1:2];
  assign w_unused_addr = {i_addr[31:AW+2], i_addr[1:0]};
  assign w_we          = i_memwrite & ~i_reset;
  assign w_re          = i_memread & ~i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_idx] <= i_invalue;
    end
  end

  // Reset forces the output low even while the array is being cleared.
  always_comb begin
    o_outvalue = '0;
    if (w_re) begin
      o_outvalue = r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a queue scoreboard.
// Expected values are queued at drive time and popped at sample time.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] invalue;
  logic        memwrite;
  logic        memread;
  logic [31:0] outvalue;

  int n_tests;
  int n_fail;
  logic [31:0] sb_q[$];

  data_memory #(.WORDS(1024), .AW(10)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_addr     (addr),
    .i_invalue  (invalue),
    .i_memwrite (memwrite),
    .i_memread  (memread),
    .o_outvalue (outvalue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [31:0] exp;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, outvalue);
    end else begin
      exp = sb_q.pop_front();
      assert (outvalue === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, outvalue, exp);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr     = a;
    invalue  = d;
    memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string tag);
    @(negedge clk);
    addr    = a;
    memread = 1'b1;
    expect_val(e);
    #1;
    check(tag);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    addr     = '0;
    invalue  = '0;
    memwrite = 1'b0;
    memread  = 1'b1;
    #1;
    reset = 1'b1;
    expect_val(32'h0);
    #2;
    check("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Reset clear
    wr(32'h0, 32'hDEADBEEF);
    rd(32'h0, 32'hDEADBEEF, "pre_reset_rd0");
    #2;
    reset = 1'b1;
    expect_val(32'h0);
    #1;
    check("async_reset_out");
    #1;
    reset = 1'b0;
    rd(32'h0, 32'h0, "reset_clear_rd0");

    // Write/read-back across words
    wr(32'h4, 32'h12345678);
    wr(32'hFFC, 32'hCAFEF00D);
    rd(32'h4, 32'h12345678, "rd_4");
    rd(32'hFFC, 32'hCAFEF00D, "rd_ffc");
    rd(32'h8, 32'h0, "rd_8_empty");

    // Read gating, no clock edge between the two samples
    @(negedge clk);
    addr    = 32'h4;
    memread = 1'b0;
    expect_val(32'h0);
    #1;
    check("gate_off");
    memread = 1'b1;
    expect_val(32'h12345678);
    #1;
    check("gate_on");

    // Alignment and wrap
    wr(32'h7, 32'hA5A5A5A5);
    rd(32'h4, 32'hA5A5A5A5, "align_7_to_4");
    wr(32'h1000, 32'h11111111);
    rd(32'h0, 32'h11111111, "wrap_1000_to_0");
    rd(32'h1004, 32'hA5A5A5A5, "wrap_1004_to_4");

    // Write enable low holds the array
    @(negedge clk);
    addr     = 32'h10;
    invalue  = 32'hFFFFFFFF;
    memwrite = 1'b0;
    @(posedge clk);
    #1;
    rd(32'h10, 32'h0, "we_low_hold");

    // Same-cycle read and write
    @(negedge clk);
    addr     = 32'h10;
    invalue  = 32'h55;
    memwrite = 1'b1;
    memread  = 1'b1;
    expect_val(32'h0);
    #1;
    check("rw_pre_edge");
    @(posedge clk);
    expect_val(32'h55);
    #1;
    check("rw_post_edge");
    memwrite = 1'b0;

    // Async reset during a write
    @(negedge clk);
    addr     = 32'h20;
    invalue  = 32'h77;
    memwrite = 1'b1;
    #2;
    reset = 1'b1;
    expect_val(32'h0);
    #1;
    check("reset_mid_write");
    @(posedge clk);
    #1;
    expect_val(32'h0);
    check("reset_over_edge");
    @(negedge clk);
    memwrite = 1'b0;
    reset    = 1'b0;
    rd(32'h20, 32'h0, "after_reset_rd20");
    rd(32'h4, 32'h0, "after_reset_rd4");
    rd(32'h10, 32'h0, "after_reset_rd10");

    // First edge with reset low accepts a write
    wr(32'h20, 32'h99);
    rd(32'h20, 32'h99, "post_reset_write");

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required",
               sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
